// File: rtl/mem_dma_if.sv
// ============================================================================
// Module   : mem_dma_if
// Brief    : Control and memory-bus bundle for the mem_dma block-copy engine.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_dma_if;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] address;
    logic [31:0] memIn;
    logic [31:0] memOut;
    logic        read;
    logic        write;

    // The DMA engine masters the memory bus and serves the control requests.
    modport master (
        input  start, src, dst, count, memOut,
        output busy, done, err, address, memIn, read, write
    );

    modport slave (
        output start, src, dst, count, memOut,
        input  busy, done, err, address, memIn, read, write
    );
endinterface

`default_nettype wire

// File: rtl/mem_dma.sv
// ============================================================================
// Module   : mem_dma
// Brief    : Word-at-a-time ascending memory block copy (read, then write).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_dma #(
    parameter int DEBUG = 0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mem_dma_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_cur_src,   w_cur_src_nxt;
    logic [31:0] r_cur_dst,   w_cur_dst_nxt;
    logic [15:0] r_remaining, w_remaining_nxt;
    logic [31:0] r_buf,       w_buf_nxt;
    logic        r_err,       w_err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cur_src   <= 32'd0;
            r_cur_dst   <= 32'd0;
            r_remaining <= 16'd0;
            r_buf       <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_src   <= w_cur_src_nxt;
            r_cur_dst   <= w_cur_dst_nxt;
            r_remaining <= w_remaining_nxt;
            r_buf       <= w_buf_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_src_nxt   = r_cur_src;
        w_cur_dst_nxt   = r_cur_dst;
        w_remaining_nxt = r_remaining;
        w_buf_nxt       = r_buf;
        w_err_nxt       = r_err;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_cur_src_nxt   = bus.src;
                    w_cur_dst_nxt   = bus.dst;
                    w_remaining_nxt = bus.count;
                    if ((bus.src[1:0] != 2'b00) || (bus.dst[1:0] != 2'b00)) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end else if (bus.count == 16'd0) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = RD;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            RD: begin
                w_buf_nxt   = bus.memOut;
                w_state_nxt = WR;
            end
            WR: begin
                // Address increments wrap modulo 2^32 by construction.
                w_cur_src_nxt   = r_cur_src + 32'd4;
                w_cur_dst_nxt   = r_cur_dst + 32'd4;
                w_remaining_nxt = r_remaining - 16'd1;
                w_state_nxt     = (r_remaining == 16'd1) ? DONE : RD;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.read    = (r_state == RD);
    assign bus.write   = (r_state == WR);
    assign bus.busy    = (r_state == RD) || (r_state == WR);
    assign bus.done    = (r_state == DONE);
    assign bus.err     = r_err;
    assign bus.memIn   = r_buf;
    assign bus.address = (r_state == RD) ? r_cur_src :
                         (r_state == WR) ? r_cur_dst : 32'd0;

    generate
        if (DEBUG != 0) begin : g_debug
            always_ff @(posedge clk) begin
                if (rst_n && (r_state == WR)) begin
                    $display("mem_dma: write addr=%08h data=%08h", r_cur_dst, r_buf);
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_dma.sv
// ============================================================================
// Module   : tb_mem_dma
// Brief    : Scoreboard bench for mem_dma with a behavioural word memory.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_dma;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_dma_if bus();

    mem_dma #(.DEBUG(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    assign bus.memOut = mem[bus.address[11:2]];
    always @(posedge clk) begin
        if (bus.write) mem[bus.address[11:2]] = bus.memIn;
    end

    typedef struct packed {
        logic        is_done;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int errors   = 0;
    int n_reads  = 0;
    int n_writes = 0;
    int n_dones  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.err = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic er);
        exp_t e;
        e.is_done = 1'b1; e.addr = 32'd0; e.data = 32'd0; e.err = er;
        sb.push_back(e);
    endtask

    // Monitor: consumes one expectation per write beat or done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        check32("rw_exclusive", {31'd0, (bus.read === 1'b1) && (bus.write === 1'b1)}, 32'd0);
        if (bus.read === 1'b1) n_reads++;
        if (bus.write === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.address, bus.memIn);
            end else begin
                e = sb.pop_front();
                check32("write_order", {31'd0, e.is_done}, 32'd0);
                check32("write_addr", bus.address, e.addr);
                check32("write_data", bus.memIn, e.data);
            end
        end
        if (bus.done === 1'b1) begin
            n_dones++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: err %b, expected no done", bus.err);
            end else begin
                e = sb.pop_front();
                check32("done_order", {31'd0, e.is_done}, 32'd1);
                check32("done_err", {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check32({name, "_busy"},  {31'd0, bus.busy},  32'd0);
        check32({name, "_done"},  {31'd0, bus.done},  32'd0);
        check32({name, "_err"},   {31'd0, bus.err},   32'd0);
        check32({name, "_read"},  {31'd0, bus.read},  32'd0);
        check32({name, "_write"}, {31'd0, bus.write}, 32'd0);
        check32({name, "_addr"},  bus.address,        32'd0);
        check32({name, "_memIn"}, bus.memIn,          32'd0);
    endtask

    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int exp_lat, input int exp_busy,
                            input logic exp_err);
        int lat;
        int busyc;
        bus.src = s; bus.dst = d; bus.count = n; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1; busyc = 0;
        while (!bus.done && lat < 300) begin
            if (bus.busy) busyc++;
            tick();
            lat++;
        end
        check32({name, "_done_edges"}, 32'(lat), 32'(exp_lat));
        check32({name, "_busy_cycles"}, 32'(busyc), 32'(exp_busy));
        check32({name, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        tick();
        check32({name, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check32({name, "_err_held"}, {31'd0, bus.err}, {31'd0, exp_err});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0;
        int r0;
        int d0;
        int lat;
        bus.start = 1'b0; bus.src = 32'd0; bus.dst = 32'd0; bus.count = 16'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        rst_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        mem[64] = 32'h11; mem[65] = 32'h22; mem[66] = 32'h33;

        // Three-word aligned copy.
        push_wr(32'h200, 32'h11); push_wr(32'h204, 32'h22); push_wr(32'h208, 32'h33);
        push_done(1'b0);
        run_copy("copy3", 32'h100, 32'h200, 16'd3, 7, 6, 1'b0);
        check32("copy3_mem200", mem[128], 32'h11);
        check32("copy3_mem204", mem[129], 32'h22);
        check32("copy3_mem208", mem[130], 32'h33);

        // Misaligned source rejected.
        w0 = n_writes;
        push_done(1'b1);
        run_copy("misaligned", 32'h102, 32'h200, 16'd4, 1, 0, 1'b1);
        check32("misaligned_no_write", 32'(n_writes - w0), 32'd0);
        check32("misaligned_mem200", mem[128], 32'h11);
        check32("misaligned_mem20c", mem[131], 32'h0);
        tick();
        check32("err_hold_idle", {31'd0, bus.err}, 32'd1);

        // Zero-length copy.
        w0 = n_writes; r0 = n_reads;
        push_done(1'b0);
        run_copy("zero", 32'h300, 32'h400, 16'd0, 1, 0, 1'b0);
        check32("zero_no_write", 32'(n_writes - w0), 32'd0);
        check32("zero_no_read", 32'(n_reads - r0), 32'd0);

        // start held high: one copy, then re-acceptance only from IDLE.
        w0 = n_writes;
        push_wr(32'h500, 32'h11); push_wr(32'h504, 32'h22); push_done(1'b0);
        push_wr(32'h500, 32'h11); push_wr(32'h504, 32'h22); push_done(1'b0);
        bus.src = 32'h100; bus.dst = 32'h500; bus.count = 16'd2; bus.start = 1'b1;
        tick();
        lat = 1;
        while (!bus.done && lat < 300) begin tick(); lat++; end
        check32("held_done_edges", 32'(lat), 32'd5);
        check32("held_single_copy", 32'(n_writes - w0), 32'd2);
        tick();
        check32("held_idle_busy", {31'd0, bus.busy}, 32'd0);
        check32("held_idle_done", {31'd0, bus.done}, 32'd0);
        tick();
        check32("held_reaccept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 300) begin tick(); lat++; end
        check32("held_second_done_edges", 32'(lat), 32'd5);
        tick();
        check32("held_total_writes", 32'(n_writes - w0), 32'd4);

        // Reset sampled at the edge that would begin word 2's write beat.
        d0 = n_dones;
        push_wr(32'h600, 32'h11);
        bus.src = 32'h100; bus.dst = 32'h600; bus.count = 16'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check32("rst_mid_in_rd", {31'd0, bus.read}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        repeat (10) tick();
        check32("rst_mid_no_done", 32'(n_dones - d0), 32'd0);
        check32("rst_mid_mem600", mem[384], 32'h11);
        check32("rst_mid_mem604", mem[385], 32'h0);

        // In-place copy leaves memory unchanged.
        push_wr(32'h104, 32'h22); push_wr(32'h108, 32'h33); push_done(1'b0);
        run_copy("inplace", 32'h104, 32'h104, 16'd2, 5, 4, 1'b0);
        check32("inplace_mem104", mem[65], 32'h22);
        check32("inplace_mem108", mem[66], 32'h33);

        // Source address wraps from 0xFFFFFFFC to 0.
        mem[1023] = 32'hAA; mem[0] = 32'hBB;
        push_wr(32'h700, 32'hAA); push_wr(32'h704, 32'hBB); push_done(1'b0);
        run_copy("wrap", 32'hFFFFFFFC, 32'h700, 16'd2, 5, 4, 1'b0);
        check32("wrap_mem700", mem[448], 32'hAA);
        check32("wrap_mem704", mem[449], 32'hBB);

        check32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 The module SHALL have parameter DEBUG, default 0; nonzero SHALL print one $display line per word written.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 The module SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The module SHALL have port start  input  1  request a block copy; sampled only in IDLE.
REQ-005 The module SHALL have port src  input  32  byte address of first source word.
REQ-006 The module SHALL have port dst  input  32  byte address of first destination word.
REQ-007 The module SHALL have port count  input  16  number of 32-bit words to copy.
REQ-008 The module SHALL have port busy  output  1  high while a copy is in progress (RD or WR).
REQ-009 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The module SHALL have port err  output  1  last request was rejected; valid from the done pulse until the next accepted start.
REQ-011 The module SHALL have port address  output  32  memory byte address.
REQ-012 The module SHALL have port memIn  output  32  memory write data.
REQ-013 The module SHALL have port memOut  input  32  memory read data; combinational response to address/read.
REQ-014 The module SHALL have port read  output  1  memory read enable.
REQ-015 The module SHALL have port write  output  1  memory write enable; memory commits on posedge clk.

Function
REQ-016 The module SHALL implement the states IDLE, RD, WR and DONE, held in registers; read, write, busy and done SHALL be decoded from state only.
REQ-017 In IDLE with start=1, the module SHALL latch src, dst and count into cur_src, cur_dst and remaining at the edge.
REQ-018 On that same edge, the next state SHALL be DONE with err set if src[1:0]!=0 or dst[1:0]!=0.
REQ-019 Otherwise, on that same edge, the next state SHALL be DONE with err clear if count==0.
REQ-020 Otherwise, on that same edge, the next state SHALL be RD with err clear.
REQ-021 In RD: read=1, write=0, address=cur_src; at the edge, buf<=memOut and the next state SHALL be WR.
REQ-022 In WR: read=0, write=1, address=cur_dst, memIn=buf; at the edge, cur_src+=4, cur_dst+=4 and remaining-=1.
REQ-023 From WR, the next state SHALL be DONE if remaining was 1 before the decrement; otherwise it SHALL be RD.
REQ-024 DONE SHALL last exactly one cycle with done=1, followed unconditionally by IDLE.
REQ-025 In IDLE and DONE: read=0, write=0, address=0 and memIn=buf.
REQ-026 busy SHALL be 1 in RD and WR and 0 in IDLE and DONE.
REQ-027 read and write SHALL never be 1 in the same cycle.
REQ-028 An N-word copy SHALL take 2N cycles in RD/WR plus one DONE cycle; done SHALL rise 2N+1 edges after the accepting edge.
REQ-029 start SHALL be ignored in RD, WR and DONE; parameters SHALL not be resampled mid-copy.
REQ-030 Address arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 wraps to 0 with no error.
REQ-031 Copies SHALL be strictly ascending; an overlapping region with dst>src SHALL propagate the earlier-written words (no overlap detection).
REQ-032 count=16'hFFFF SHALL copy 65535 words; remaining SHALL not underflow.
REQ-033 err SHALL hold its value from the done pulse until the next start is accepted in IDLE.

Reset
REQ-034 At any edge with rst_n=0, the module SHALL enter IDLE and clear cur_src, cur_dst, remaining, buf and err; this overrides start.
REQ-035 After reset, all outputs SHALL be 0: busy, done, err, read, write, address and memIn.
REQ-036 Reset asserted during RD or WR SHALL drop read and write in the cycle after that edge, produce no done pulse, and write no further words.

Verification
REQ-037 The bench SHALL cover: mem preloaded with words 0x11,0x22,0x33 at 0x100; start with src=0x100, dst=0x200, count=3 -> 0x200/0x204/0x208 hold 0x11/0x22/0x33, done rises 7 edges after acceptance, err=0, busy high for 6 cycles.
REQ-038 The bench SHALL cover: src=0x102, dst=0x200, count=4 -> done on the next cycle with err=1, write never asserted, memory unchanged.
REQ-039 The bench SHALL cover: count=0 with aligned addresses -> done on the next cycle with err=0, read and write never asserted.
REQ-040 The bench SHALL cover: start held high throughout a 2-word copy -> exactly one copy is performed; a new copy is accepted only in the IDLE cycle after done.
REQ-041 The bench SHALL cover: rst_n=0 during the WR of word 2 of a 4-word copy -> only word 1 is written, all outputs are 0 the next cycle, and no done pulse occurs.
REQ-042 The bench SHALL cover: src=dst=0x104, count=2 -> memory contents unchanged, done after 5 edges, and a checker confirms read&write is never 1 in any cycle.
